// File: rtl/tag_array_ctrl_if.sv
// Client-side bundle for tag_array_ctrl: lookup request/response, tag update
// (fill) request, flush pulse and busy status.
//   master : the client that issues lookups, updates and flushes
//   slave  : the tag array controller
interface tag_array_ctrl_if #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
);
  logic             lkp_valid;
  logic             lkp_ready;
  logic [IDX_W-1:0] lkp_index;
  logic [TAG_W-1:0] lkp_tag;

  logic             rsp_valid;
  logic             rsp_hit;
  logic [IDX_W-1:0] rsp_index;

  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_index;
  logic [TAG_W-1:0] upd_tag;

  logic             flush;
  logic             busy;

  modport master (
    output lkp_valid, lkp_index, lkp_tag,
    output upd_valid, upd_index, upd_tag,
    output flush,
    input  lkp_ready, upd_ready, rsp_valid, rsp_hit, rsp_index, busy
  );

  modport slave (
    input  lkp_valid, lkp_index, lkp_tag,
    input  upd_valid, upd_index, upd_tag,
    input  flush,
    output lkp_ready, upd_ready, rsp_valid, rsp_hit, rsp_index, busy
  );
endinterface

// File: rtl/tag_array_ctrl.sv
// Tag array controller in front of a single-port tag SRAM.
// After reset or flush it sweeps every set writing zero (INIT), then serves
// tag updates (fills) and lookups. A lookup reads the SRAM, and one cycle
// later (CMP) compares the read tag against the requested one, qualified by a
// per-set valid bit held in flops.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   bus      tag_array_ctrl_if.slave: lookup/response, update, flush, busy
//   tag_CS   SRAM chip select
//   tag_OE   SRAM output enable
//   tag_WEB  SRAM write enable, active low
//   tag_A    SRAM address
//   tag_DI   SRAM write data
//   tag_DO   SRAM read data, valid the cycle after a read
module tag_array_ctrl #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
) (
  input  logic                clk,
  input  logic                rst,
  tag_array_ctrl_if.slave     bus,
  output logic                tag_CS,
  output logic                tag_OE,
  output logic                tag_WEB,
  output logic [IDX_W-1:0]    tag_A,
  output logic [TAG_W-1:0]    tag_DI,
  input  logic [TAG_W-1:0]    tag_DO
);

  localparam int NUM_SETS = 1 << IDX_W;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_CMP  = 2'd2;

  logic [1:0]          state;
  logic [IDX_W-1:0]    counter;
  logic [NUM_SETS-1:0] valid;
  logic                flush_pending;
  logic [IDX_W-1:0]    lat_index;
  logic [TAG_W-1:0]    lat_tag;

  logic in_idle;
  logic do_flush;
  logic do_upd;
  logic do_lkp;

  // Decisions are only taken in IDLE and never while rst is high, so every
  // strobe below is already forced low during reset.
  assign in_idle  = !rst && (state == ST_IDLE);
  assign do_flush = in_idle && (bus.flush || flush_pending);
  assign do_upd   = in_idle && !do_flush && bus.upd_valid;
  assign do_lkp   = in_idle && !do_flush && !bus.upd_valid && bus.lkp_valid;

  assign bus.upd_ready = in_idle && !bus.flush && !flush_pending;
  assign bus.lkp_ready = in_idle && !bus.upd_valid && !bus.flush && !flush_pending;
  assign bus.busy      = rst || (state == ST_INIT);
  assign bus.rsp_valid = !rst && (state == ST_CMP);
  assign bus.rsp_index = lat_index;
  // The valid bit masks stale SRAM contents, including the zeros left by INIT.
  assign bus.rsp_hit   = bus.rsp_valid && valid[lat_index] && (tag_DO == lat_tag);

  // SRAM command decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    tag_CS  = 1'b0;
    tag_WEB = 1'b1;
    tag_OE  = 1'b0;
    tag_A   = '0;
    tag_DI  = '0;
    if (!rst) begin
      case (state)
        ST_INIT: begin
          tag_CS  = 1'b1;
          tag_WEB = 1'b0;
          tag_A   = counter;
        end
        ST_IDLE: begin
          if (do_upd) begin
            tag_CS  = 1'b1;
            tag_WEB = 1'b0;
            tag_A   = bus.upd_index;
            tag_DI  = bus.upd_tag;
          end else if (do_lkp) begin
            tag_CS = 1'b1;
            tag_OE = 1'b1;
            tag_A  = bus.lkp_index;
          end
        end
        ST_CMP: begin
          // Keep the output driver on while the read data is consumed.
          tag_OE = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Control state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state         <= ST_INIT;
      counter       <= '0;
      valid         <= '0;
      flush_pending <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          // flush is deliberately ignored here; the sweep is already zeroing.
          counter <= counter + 1'b1;
          if (&counter) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (do_flush) begin
            state         <= ST_INIT;
            counter       <= '0;
            valid         <= '0;
            flush_pending <= 1'b0;
          end else if (do_upd) begin
            valid[bus.upd_index] <= 1'b1;
          end else if (do_lkp) begin
            state <= ST_CMP;
          end
        end
        ST_CMP: begin
          state <= ST_IDLE;
          // A flush arriving mid-compare is remembered, not dropped.
          if (bus.flush) flush_pending <= 1'b1;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Lookup capture register.
  // NOTE: pure datapath, deliberately without reset: it is only observed
  // while rsp_valid is high, which always follows a fresh capture.
  always_ff @(posedge clk) begin
    if (do_lkp) begin
      lat_index <= bus.lkp_index;
      lat_tag   <= bus.lkp_tag;
    end
  end

endmodule

// File: tb/tb_tag_array_ctrl.sv
// Self-checking bench for tag_array_ctrl: directed scenarios followed by a
// randomized mix of updates, lookups and flushes, with hit expectations taken
// from a transaction-level model of the tag array (per-set valid + tag).
module tb_tag_array_ctrl;
  localparam int IDX_W = 6;
  localparam int TAG_W = 22;
  localparam int NSETS = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tag_array_ctrl_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

  logic             tag_CS, tag_OE, tag_WEB;
  logic [IDX_W-1:0] tag_A;
  logic [TAG_W-1:0] tag_DI;
  logic [TAG_W-1:0] tag_DO;

  tag_array_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .tag_CS (tag_CS),
    .tag_OE (tag_OE),
    .tag_WEB(tag_WEB),
    .tag_A  (tag_A),
    .tag_DI (tag_DI),
    .tag_DO (tag_DO)
  );

  // Synchronous single-port SRAM: write when CS && !WEB, read data next cycle.
  logic [TAG_W-1:0] mem [NSETS];
  always @(posedge clk) begin
    if (tag_CS && !tag_WEB) mem[tag_A] <= tag_DI;
    if (tag_CS && tag_WEB)  tag_DO <= mem[tag_A];
  end

  // Reference: what the tag array should hold, at transaction level.
  logic             ref_valid [NSETS];
  logic [TAG_W-1:0] ref_tag   [NSETS];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.lkp_valid = 1'b0;
    bus.lkp_index = '0;
    bus.lkp_tag   = '0;
    bus.upd_valid = 1'b0;
    bus.upd_index = '0;
    bus.upd_tag   = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < NSETS; i++) ref_valid[i] = 1'b0;
  endtask

  // Expects INIT to be in its first cycle now; optionally pulses flush at
  // sweep cycle flush_at, which must not disturb the sweep.
  task automatic run_sweep(input int flush_at);
    for (int i = 0; i < NSETS; i++) begin
      bus.flush = (i == flush_at);
      @(negedge clk);
      check("sweep_ctl", {bus.busy, tag_CS, tag_WEB, tag_OE, bus.lkp_ready, bus.upd_ready},
            6'b110000);
      check("sweep_addr", {tag_A, tag_DI}, {IDX_W'(i), {TAG_W{1'b0}}});
      step();
    end
    bus.flush = 1'b0;
    clear_ref();
    @(negedge clk);
    check("sweep_done", {bus.busy, bus.lkp_ready, bus.upd_ready}, 3'b011);
    step();
  endtask

  task automatic do_upd(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag);
    bus.upd_valid = 1'b1;
    bus.upd_index = idx;
    bus.upd_tag   = tag;
    @(negedge clk);
    check("upd_ready", bus.upd_ready, 1'b1);
    check("upd_sram", {tag_CS, tag_WEB, tag_OE, tag_A, tag_DI}, {3'b100, idx, tag});
    step();
    bus.upd_valid = 1'b0;
    ref_valid[idx] = 1'b1;
    ref_tag[idx]   = tag;
  endtask

  task automatic do_lkp(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag);
    logic exp_hit;
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);
    bus.lkp_valid = 1'b1;
    bus.lkp_index = idx;
    bus.lkp_tag   = tag;
    @(negedge clk);
    check("lkp_ready", bus.lkp_ready, 1'b1);
    check("lkp_sram", {tag_CS, tag_WEB, tag_OE, tag_A}, {3'b111, idx});
    step();
    bus.lkp_valid = 1'b0;
    bus.lkp_tag   = ~tag;   // response must use the captured tag
    @(negedge clk);
    check("rsp", {bus.rsp_valid, bus.rsp_hit, bus.rsp_index, bus.lkp_ready, bus.upd_ready,
                  tag_CS, tag_OE},
          {1'b1, exp_hit, idx, 4'b0001});
    step();
    @(negedge clk);
    check("rsp_one_cycle", bus.rsp_valid, 1'b0);
    step();
  endtask

  // Flush from IDLE with a competing update that must lose.
  task automatic do_flush_idle();
    bus.flush     = 1'b1;
    bus.upd_valid = 1'b1;
    bus.upd_index = IDX_W'($urandom_range(0, 7));
    bus.upd_tag   = TAG_W'($urandom);
    @(negedge clk);
    check("flush_idle", {bus.lkp_ready, bus.upd_ready, tag_CS, bus.busy}, 4'b0000);
    step();
    idle_inputs();
    run_sweep(-1);
  endtask

  initial begin
    clear_ref();
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();

    // Reset forces outputs even with requests pending.
    bus.lkp_valid = 1'b1;
    bus.upd_valid = 1'b1;
    @(negedge clk);
    check("reset_out", {bus.rsp_valid, bus.lkp_ready, bus.upd_ready, bus.busy,
                        tag_CS, tag_WEB, tag_OE}, 7'b0001010);
    step();
    idle_inputs();
    rst = 1'b0;
    run_sweep(-1);

    // Hit and tag mismatch on an updated set.
    do_upd(IDX_W'(5), TAG_W'(22'h12345));
    do_lkp(IDX_W'(5), TAG_W'(22'h12345));
    check("model_hit5", ref_valid[5], 1'b1);
    do_lkp(IDX_W'(5), TAG_W'(22'h12346));

    // Never-written set reads zero but must still miss.
    do_lkp(IDX_W'(9), TAG_W'(0));

    // Update wins over lookup to the same set; lookup follows and hits.
    bus.upd_valid = 1'b1;
    bus.upd_index = IDX_W'(7);
    bus.upd_tag   = TAG_W'(22'h3FFFFF);
    bus.lkp_valid = 1'b1;
    bus.lkp_index = IDX_W'(7);
    bus.lkp_tag   = TAG_W'(22'h3FFFFF);
    @(negedge clk);
    check("upd_beats_lkp", {bus.upd_ready, bus.lkp_ready}, 2'b10);
    step();
    bus.upd_valid = 1'b0;
    ref_valid[7] = 1'b1;
    ref_tag[7]   = TAG_W'(22'h3FFFFF);
    do_lkp(IDX_W'(7), TAG_W'(22'h3FFFFF));

    // Flush during CMP: response completes, pending flush taken next cycle,
    // a flush pulse mid-sweep is ignored.
    bus.lkp_valid = 1'b1;
    bus.lkp_index = IDX_W'(5);
    bus.lkp_tag   = TAG_W'(22'h12345);
    @(negedge clk);
    check("lkp_ready_pre_flush", bus.lkp_ready, 1'b1);
    step();
    bus.lkp_valid = 1'b0;
    bus.flush     = 1'b1;
    @(negedge clk);
    check("rsp_during_flush", {bus.rsp_valid, bus.rsp_hit, bus.rsp_index}, {2'b11, IDX_W'(5)});
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_pending", {bus.busy, bus.lkp_ready, bus.upd_ready, tag_CS}, 4'b0000);
    step();
    run_sweep(20);
    do_lkp(IDX_W'(5), TAG_W'(22'h12345));

    // Reset while in CMP kills the response and restarts the sweep.
    do_upd(IDX_W'(2), TAG_W'(22'h00ABC));
    bus.lkp_valid = 1'b1;
    bus.lkp_index = IDX_W'(2);
    bus.lkp_tag   = TAG_W'(22'h00ABC);
    @(negedge clk);
    check("lkp_ready_pre_rst", bus.lkp_ready, 1'b1);
    step();
    bus.lkp_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_cmp", {bus.rsp_valid, bus.busy, tag_CS, tag_WEB, tag_OE,
                         bus.lkp_ready, bus.upd_ready}, 7'b0101000);
    step();
    rst = 1'b0;
    run_sweep(-1);
    do_lkp(IDX_W'(2), TAG_W'(22'h00ABC));

    // Randomized mix over a small index/tag space so hits are frequent.
    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      logic [IDX_W-1:0] idx;
      logic [TAG_W-1:0] tag;
      r   = $urandom_range(0, 99);
      idx = IDX_W'($urandom_range(0, 7));
      tag = TAG_W'($urandom_range(0, 3));
      if (r < 40)      do_upd(idx, tag);
      else if (r < 96) do_lkp(idx, tag);
      else             do_flush_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
